texter_out_sched: RTL and testbench



---
 rtl/texter_out_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_texter_out_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/texter_out_sched.sv
// ---------------------------------------------------------------------------
// texter_out_sched
//
// Output scheduler for the single-button texter. Character, space and
// backspace events from texter_control are queued in a small circular FIFO,
// expanded into short byte sequences and handed one byte at a time to the
// shared serial transmitter through a start/busy handshake. The block also
// tracks the terminal column so it can wrap lines automatically and refuse
// to backspace past the start of a line.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   ev_char    one-cycle strobe: enqueue a character event with char_code
//   ev_space   one-cycle strobe: enqueue a space event
//   ev_back    one-cycle strobe: enqueue a backspace event
//   char_code  ASCII code, sampled only with ev_char
//   tx_busy    transmitter busy, high while a byte is being shifted out
//   tx_start   one-cycle strobe, tx_data valid in the same cycle
//   tx_data    byte to transmit, holds its value between strobes
//   full       FIFO holds DEPTH entries
//   overflow   sticky, set when an event had to be dropped
//   col        current terminal column, 0..LINE_LEN-1
// ---------------------------------------------------------------------------
module texter_out_sched #(
  parameter int DEPTH    = 8,   // power of two, >= 2
  parameter int LINE_LEN = 16   // >= 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ev_char,
  input  logic                              ev_space,
  input  logic                              ev_back,
  input  logic [7:0]                        char_code,
  input  logic                              tx_busy,
  output logic                              tx_start,
  output logic [7:0]                        tx_data,
  output logic                              full,
  output logic                              overflow,
  output logic [$clog2(LINE_LEN+1)-1:0]     col
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int COL_W = $clog2(LINE_LEN + 1);

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_CHAR  = 2'd1,
    EV_SPACE = 2'd2,
    EV_BACK  = 2'd3
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] code;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    ISSUE,
    GAP,
    WAIT
  } state_t;

  // -------------------------------------------------------------------------
  // Event selection: one event per cycle, backspace wins, then char, then
  // space. Losing strobes are simply ignored.
  // -------------------------------------------------------------------------
  entry_t in_entry;
  logic   ev_any;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_entry = '{kind: EV_NONE, code: 8'h00};
    ev_any   = 1'b0;
    if (ev_back) begin
      in_entry = '{kind: EV_BACK, code: 8'h00};
      ev_any   = 1'b1;
    end else if (ev_char) begin
      in_entry = '{kind: EV_CHAR, code: char_code};
      ev_any   = 1'b1;
    end else if (ev_space) begin
      in_entry = '{kind: EV_SPACE, code: 8'h20};
      ev_any   = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  state_t             state;
  logic               pop;
  logic               accept;
  entry_t             head;

  assign pop    = (state == POP);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign accept = ev_any && ((count < CNT_W'(DEPTH)) || pop);
  assign full   = (count == CNT_W'(DEPTH));
  assign head   = mem[rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are valid, so clearing the data itself buys nothing.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= in_entry;
  end

  // NOTE: sequential state is only ever assigned with non-blocking <=, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ev_any && !accept) overflow <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sequence construction from the head entry and the current column.
  // Only evaluated meaningfully in POP.
  // -------------------------------------------------------------------------
  logic [1:0]       pop_len;
  logic [COL_W-1:0] col_next;

  always_comb begin
    pop_len  = 2'd0;
    col_next = col;
    case (head.kind)
      EV_CHAR, EV_SPACE: begin
        if (col == COL_W'(LINE_LEN - 1)) begin
          pop_len  = 2'd3;              // code, CR, LF
          col_next = '0;
        end else begin
          pop_len  = 2'd1;
          col_next = col + COL_W'(1);
        end
      end
      EV_BACK: begin
        // Never erase across a line boundary.
        if (col != '0) begin
          pop_len  = 2'd3;              // BS, space, BS
          col_next = col - COL_W'(1);
        end
      end
      default: begin
        pop_len  = 2'd0;
        col_next = col;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Active sequence and byte selection
  // -------------------------------------------------------------------------
  logic       seq_back;
  logic [7:0] seq_code;
  logic [1:0] seq_len;
  logic [1:0] idx;
  logic [1:0] idx_next;
  logic [7:0] cur_byte;
  logic [7:0] last_data;

  assign idx_next = idx + 2'd1;

  always_comb begin
    cur_byte = 8'h00;
    if (seq_back) begin
      case (idx)
        2'd1:    cur_byte = 8'h20;
        default: cur_byte = 8'h08;
      endcase
    end else begin
      case (idx)
        2'd0:    cur_byte = seq_code;
        2'd1:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
    end
  end

  // tx_start has to react to tx_busy in the very cycle ISSUE is entered to
  // meet the two-cycle event-to-strobe latency, so it is decoded from the
  // registered state rather than registered itself. Reset suppresses it so
  // an abandoned sequence never emits another strobe.
  assign tx_start = (state == ISSUE) && !tx_busy && !reset;
  assign tx_data  = tx_start ? cur_byte : last_data;

  // -------------------------------------------------------------------------
  // Scheduler FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      seq_back  <= 1'b0;
      seq_code  <= 8'h00;
      seq_len   <= 2'd0;
      idx       <= 2'd0;
      col       <= '0;
      last_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          // Looking at accept as well lets a fresh event go straight to POP.
          if ((count != '0) || accept) state <= POP;
        end
        POP: begin
          seq_back <= (head.kind == EV_BACK);
          seq_code <= head.code;
          seq_len  <= pop_len;
          idx      <= 2'd0;
          col      <= col_next;
          state    <= (pop_len == 2'd0) ? IDLE : ISSUE;
        end
        ISSUE: begin
          if (!tx_busy) begin
            last_data <= cur_byte;
            state     <= GAP;
          end
        end
        GAP: begin
          // Busy is ignored here; the transmitter raises it one cycle late.
          state <= WAIT;
        end
        WAIT: begin
          if (!tx_busy) begin
            idx   <= idx_next;
            state <= (idx_next < seq_len) ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_texter_out_sched.sv
// ---------------------------------------------------------------------------
// tb_texter_out_sched
//
// Self-checking bench for texter_out_sched (DEPTH=8, LINE_LEN=16). A simple
// transmitter model raises busy for busy_len cycles after each tx_start, and
// a monitor collects every transmitted byte. Single events are checked from a
// vector table; latency, line wrap, FIFO fill/overflow, priority and reset
// mid-sequence are checked by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_texter_out_sched;

  localparam int DEPTH    = 8;
  localparam int LINE_LEN = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       ev_char;
  logic       ev_space;
  logic       ev_back;
  logic [7:0] char_code;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       overflow;
  logic [4:0] col;

  texter_out_sched #(.DEPTH(DEPTH), .LINE_LEN(LINE_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .ev_char   (ev_char),
    .ev_space  (ev_space),
    .ev_back   (ev_back),
    .char_code (char_code),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .full      (full),
    .overflow  (overflow),
    .col       (col)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transmitter model: busy for busy_len cycles after each start; not reset.
  int   busy_len   = 2;
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_start === 1'b1) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Byte monitor, sampled on the falling edge.
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         busy_viol = 0;

  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      got.push_back(tx_data);
      if (tx_busy) busy_viol++;
    end
  end

  typedef struct {
    logic [1:0] kind;     // 1 char, 2 space, 3 back
    logic [7:0] code;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [4:0] col_exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_inputs();
    ev_char  = 1'b0;
    ev_space = 1'b0;
    ev_back  = 1'b0;
  endtask

  task automatic send(input logic [1:0] kind, input logic [7:0] code);
    ev_char   = (kind == 2'd1);
    ev_space  = (kind == 2'd2);
    ev_back   = (kind == 2'd3);
    char_code = code;
    tick();
    clear_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    got.delete();
  endtask

  task automatic compare_bytes(input string name);
    logic [7:0] act;
    check({name, " byte count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      check($sformatf("%s byte %0d", name, i), act, exp_q[i]);
    end
  endtask

  initial begin
    reset     = 1'b1;
    char_code = 8'h00;
    clear_inputs();

    // ---------------- reset state ----------------
    do_reset();
    check("reset tx_start", tx_start, 1'b0);
    check("reset tx_data", tx_data, 8'h00);
    check("reset full", full, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check("reset col", col, 5'd0);

    // ---------------- event-to-strobe latency ----------------
    ev_char   = 1'b1;
    char_code = 8'h41;
    @(negedge clk);
    check("latency cycle n", tx_start, 1'b0);
    tick();
    clear_inputs();
    @(negedge clk);
    check("latency cycle n+1", tx_start, 1'b0);
    @(negedge clk);
    check("latency cycle n+2 start", tx_start, 1'b1);
    check("latency cycle n+2 data", tx_data, 8'h41);
    check("latency col", col, 5'd1);
    tick();
    wait_cycles(20);

    // ---------------- single-event vector table ----------------
    vecs[0] = '{kind: 2'd1, code: 8'h48, n: 1, b0: 8'h48, b1: 8'h00, b2: 8'h00, col_exp: 5'd1};
    vecs[1] = '{kind: 2'd1, code: 8'h49, n: 1, b0: 8'h49, b1: 8'h00, b2: 8'h00, col_exp: 5'd2};
    vecs[2] = '{kind: 2'd3, code: 8'h00, n: 3, b0: 8'h08, b1: 8'h20, b2: 8'h08, col_exp: 5'd1};
    vecs[3] = '{kind: 2'd3, code: 8'h00, n: 3, b0: 8'h08, b1: 8'h20, b2: 8'h08, col_exp: 5'd0};
    vecs[4] = '{kind: 2'd3, code: 8'h00, n: 0, b0: 8'h00, b1: 8'h00, b2: 8'h00, col_exp: 5'd0};
    vecs[5] = '{kind: 2'd2, code: 8'h77, n: 1, b0: 8'h20, b1: 8'h00, b2: 8'h00, col_exp: 5'd1};
    vecs[6] = '{kind: 2'd3, code: 8'h00, n: 3, b0: 8'h08, b1: 8'h20, b2: 8'h08, col_exp: 5'd0};

    do_reset();
    for (int v = 0; v < 7; v++) begin
      got.delete();
      send(vecs[v].kind, vecs[v].code);
      wait_cycles(30);
      exp_q.delete();
      if (vecs[v].n > 0) exp_q.push_back(vecs[v].b0);
      if (vecs[v].n > 1) exp_q.push_back(vecs[v].b1);
      if (vecs[v].n > 2) exp_q.push_back(vecs[v].b2);
      compare_bytes($sformatf("vec%0d", v));
      check($sformatf("vec%0d col", v), col, vecs[v].col_exp);
    end

    // ---------------- line wrap with a slow transmitter ----------------
    do_reset();
    busy_len = 10;
    for (int i = 0; i < 16; i++) begin
      send(2'd1, 8'h45);
      wait_cycles(9);
    end
    wait_cycles(400);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h45);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    compare_bytes("wrap");
    check("wrap col", col, 5'd0);
    check("wrap overflow", overflow, 1'b0);

    // ---------------- FIFO fill and overflow ----------------
    do_reset();
    busy_len   = 2;
    force_busy = 1'b1;
    for (int i = 0; i < 9; i++) send(2'd1, 8'(8'h30 + i));
    check("fill full", full, 1'b1);
    check("fill overflow before drop", overflow, 1'b0);
    check("fill no bytes while busy", got.size(), 0);
    send(2'd1, 8'h39);
    check("overflow set", overflow, 1'b1);
    wait_cycles(5);
    check("overflow sticky", overflow, 1'b1);
    force_busy = 1'b0;
    wait_cycles(150);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h30 + i));
    compare_bytes("fill");
    check("fill full after drain", full, 1'b0);
    check("overflow still set", overflow, 1'b1);
    check("fill col", col, 5'd9);

    // ---------------- same-cycle priority ----------------
    do_reset();
    send(2'd1, 8'h31);
    wait_cycles(30);
    send(2'd1, 8'h32);
    wait_cycles(30);
    send(2'd1, 8'h33);
    wait_cycles(30);
    check("prio start col", col, 5'd3);
    got.delete();
    ev_char   = 1'b1;
    ev_back   = 1'b1;
    char_code = 8'h5A;
    tick();
    clear_inputs();
    wait_cycles(40);
    exp_q.delete();
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h08);
    compare_bytes("prio");
    check("prio col", col, 5'd2);
    check("prio overflow", overflow, 1'b0);

    // ---------------- reset during GAP ----------------
    do_reset();
    send(2'd1, 8'h51);
    wait_cycles(30);
    send(2'd1, 8'h52);
    wait_cycles(30);
    got.delete();
    ev_back = 1'b1;        // cycle n
    tick();
    clear_inputs();        // cycle n+1: POP
    tick();                // cycle n+2: ISSUE, first BS sent
    tick();                // cycle n+3: GAP
    reset = 1'b1;
    tick();                // cycle n+4: reset has taken effect
    reset = 1'b0;
    check("rst gap tx_start", tx_start, 1'b0);
    check("rst gap col", col, 5'd0);
    check("rst gap full", full, 1'b0);
    wait_cycles(30);
    exp_q.delete();
    exp_q.push_back(8'h08);
    compare_bytes("rst gap abandoned");
    send(2'd1, 8'h61);
    wait_cycles(30);
    exp_q.push_back(8'h61);
    compare_bytes("rst gap resume");
    check("rst gap resume col", col, 5'd1);

    check("tx_start while busy", busy_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
